// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the CPU wait-state memory: FSM state encodings and
// the default bus widths that the CPU side also uses.
package cpu_memory_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_memory_array.sv
// DEPTH x DATA_W storage with one synchronous write port and an asynchronous
// read port. Contents are deliberately not reset so a preloaded image survives.
module cpu_memory_array
  import cpu_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/cpu_memory.sv
// Wait-state memory below the CPU: one read or write per request, answered by
// a one-cycle mem_ready pulse, plus a loader port for preloading the image.
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_bus,
  output logic              mem_ready,
  output logic              busy,
  output logic              err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [DATA_W-1:0] data_bus_q, data_bus_d;
  logic              mem_ready_q, mem_ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              ack_entry;
  logic              ld_we;
  logic              cpu_we;
  logic [ADDR_W-1:0] acc_adr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_is_wr;
  logic              acc_ok;
  logic [DATA_W-1:0] rd_data;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_wr_idx;
  logic [DATA_W-1:0] arr_wr_data;

  // With zero wait states the access completes straight from IDLE, so the
  // live bus is used instead of the (not yet loaded) latches.
  assign acc_adr   = (state_q == ST_IDLE) ? adr_bus : adr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? data_in : wdata_q;
  assign acc_is_wr = (state_q == ST_IDLE) ? wr_mem  : is_wr_q;
  assign acc_ok    = in_range(acc_adr);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    data_bus_d  = data_bus_q;
    mem_ready_d = 1'b0;
    err_d       = 1'b0;
    ack_entry   = 1'b0;
    ld_we       = 1'b0;
    cpu_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ld_en) begin
          ld_we = in_range(ld_adr);
        end else if (rd_mem && wr_mem) begin
          err_d = 1'b1;
        end else if (rd_mem || wr_mem) begin
          adr_d   = adr_bus;
          wdata_d = data_in;
          is_wr_d = wr_mem;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d   = ST_ACK;
            ack_entry = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        err_d = ld_en;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d   = ST_ACK;
          ack_entry = 1'b1;
        end
      end
      ST_ACK: begin
        err_d   = ld_en;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Out-of-range accesses still complete, but read as zero and drop writes.
    if (ack_entry) begin
      mem_ready_d = 1'b1;
      if (!acc_ok) begin
        err_d = 1'b1;
      end
      if (acc_is_wr) begin
        cpu_we = acc_ok;
      end else begin
        data_bus_d = acc_ok ? rd_data : '0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      data_bus_q  <= '0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      data_bus_q  <= data_bus_d;
      mem_ready_q <= mem_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Loader writes only in IDLE and CPU writes only on ACK entry, so one port suffices.
  assign arr_we      = ld_we || cpu_we;
  assign arr_wr_idx  = ld_we ? ld_adr[IDX_W-1:0] : acc_adr[IDX_W-1:0];
  assign arr_wr_data = ld_we ? ld_data : acc_wdata;

  cpu_memory_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .wr_idx  (arr_wr_idx),
    .wr_data (arr_wr_data),
    .rd_idx  (acc_adr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  assign data_bus  = data_bus_q;
  assign mem_ready = mem_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory: three instances share one stimulus bus
// (A: 2 wait states, B: DEPTH=128, C: zero wait states).
module tb_cpu_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  adr_bus;
  logic        rd_mem, wr_mem;
  logic [15:0] data_in;
  logic        ld_en;
  logic [7:0]  ld_adr;
  logic [15:0] ld_data;

  logic [15:0] data_bus_a, data_bus_b, data_bus_c;
  logic        mem_ready_a, mem_ready_b, mem_ready_c;
  logic        busy_a, busy_b, busy_c;
  logic        err_a, err_b, err_c;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cpu_memory #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .data_in(data_in), .data_bus(data_bus_a), .mem_ready(mem_ready_a), .busy(busy_a),
    .err(err_a), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data));

  cpu_memory #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_STATES(2)) dut_b (
    .clk(clk), .reset(reset), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .data_in(data_in), .data_bus(data_bus_b), .mem_ready(mem_ready_b), .busy(busy_b),
    .err(err_b), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data));

  cpu_memory #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_STATES(0)) dut_c (
    .clk(clk), .reset(reset), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .data_in(data_in), .data_bus(data_bus_c), .mem_ready(mem_ready_c), .busy(busy_c),
    .err(err_c), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [15:0] d);
    ld_adr = a; ld_data = d; ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic settle();
    rd_mem = 1'b0; wr_mem = 1'b0; ld_en = 1'b0;
    repeat (5) tick();
  endtask

  // Full two-wait-state access: request sampled, two WAIT cycles, ACK, back to IDLE.
  task automatic run_access(input logic wr, input logic [7:0] a, input logic [15:0] d);
    adr_bus = a; data_in = d; wr_mem = wr; rd_mem = !wr;
    repeat (3) tick();
    rd_mem = 1'b0; wr_mem = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    tests_run++;
    if ({data_bus_a, mem_ready_a, busy_a, err_a} !== 19'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got %h expected 0", {data_bus_a, mem_ready_a, busy_a, err_a});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_read();
    logic exp_ready;
    do_load(8'h05, 16'h1234);
    adr_bus = 8'h05; rd_mem = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_ready = (k == 3);
      tests_run++;
      if (mem_ready_a !== exp_ready) begin
        tests_failed++;
        $display("[TB] FAIL load_read_ready cycle N+%0d got %b expected %b", k, mem_ready_a, exp_ready);
      end
      if (k == 3) rd_mem = 1'b0;
      if (k >= 3) begin
        tests_run++;
        if (data_bus_a !== 16'h1234) begin
          tests_failed++;
          $display("[TB] FAIL load_read_data cycle N+%0d got %h expected 1234", k, data_bus_a);
        end
      end
    end
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_read_busy_after got %b expected 0", busy_a);
    end
  endtask

  task automatic test_write_read();
    logic exp_ready;
    adr_bus = 8'h10; data_in = 16'hBEEF; wr_mem = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_ready = (k == 3);
      tests_run++;
      if (mem_ready_a !== exp_ready || data_bus_a !== 16'h1234) begin
        tests_failed++;
        $display("[TB] FAIL write_cycle N+%0d got ready=%b data=%h expected ready=%b data=1234",
                 k, mem_ready_a, data_bus_a, exp_ready);
      end
      if (k == 3) wr_mem = 1'b0;
    end
    run_access(1'b0, 8'h10, 16'h0000);
    tests_run++;
    if (data_bus_a !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL write_then_read got %h expected beef", data_bus_a);
    end
  endtask

  task automatic test_protocol_error();
    adr_bus = 8'h10; data_in = 16'hDEAD; rd_mem = 1'b1; wr_mem = 1'b1;
    tick();
    rd_mem = 1'b0; wr_mem = 1'b0;
    tests_run++;
    if (err_a !== 1'b1 || mem_ready_a !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL both_req_err got err=%b ready=%b busy=%b expected 1 0 0", err_a, mem_ready_a, busy_a);
    end
    tick();
    tests_run++;
    if (err_a !== 1'b0 || mem_ready_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL both_req_pulse got err=%b ready=%b expected 0 0", err_a, mem_ready_a);
    end
    run_access(1'b0, 8'h10, 16'h0000);
    tests_run++;
    if (data_bus_a !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL both_req_mem_unchanged got %h expected beef", data_bus_a);
    end
  endtask

  task automatic test_range_error();
    adr_bus = 8'hF0; rd_mem = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (mem_ready_b !== 1'b0 || err_b !== 1'b0 || data_bus_b !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL range_before_ack got ready=%b err=%b data=%h expected 0 0 beef",
               mem_ready_b, err_b, data_bus_b);
    end
    tick();
    rd_mem = 1'b0;
    tests_run++;
    if (mem_ready_b !== 1'b1 || err_b !== 1'b1 || data_bus_b !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL range_ack got ready=%b err=%b data=%h expected 1 1 0000",
               mem_ready_b, err_b, data_bus_b);
    end
    tests_run++;
    if (err_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL in_range_no_err got %b expected 0", err_a);
    end
  endtask

  task automatic test_load_collision();
    do_load(8'h40, 16'h7777);
    adr_bus = 8'h40; rd_mem = 1'b1;
    tick();
    ld_adr = 8'h40; ld_data = 16'h9999; ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
    tests_run++;
    if (err_a !== 1'b1 || mem_ready_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ld_wait_err got err=%b ready=%b expected 1 0", err_a, mem_ready_a);
    end
    tick();
    rd_mem = 1'b0;
    tests_run++;
    if (mem_ready_a !== 1'b1 || err_a !== 1'b0 || data_bus_a !== 16'h7777) begin
      tests_failed++;
      $display("[TB] FAIL ld_wait_read got ready=%b err=%b data=%h expected 1 0 7777",
               mem_ready_a, err_a, data_bus_a);
    end
    tick();
    run_access(1'b0, 8'h40, 16'h0000);
    tests_run++;
    if (data_bus_a !== 16'h7777) begin
      tests_failed++;
      $display("[TB] FAIL ld_wait_dropped got %h expected 7777", data_bus_a);
    end
  endtask

  task automatic test_reset_midstream();
    do_load(8'h20, 16'h5A5A);
    run_access(1'b0, 8'h20, 16'h0000);
    tests_run++;
    if (data_bus_a !== 16'h5A5A) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_read got %h expected 5a5a", data_bus_a);
    end
    adr_bus = 8'h20; rd_mem = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({data_bus_a, mem_ready_a, busy_a, err_a} !== 19'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got %h expected 0", {data_bus_a, mem_ready_a, busy_a, err_a});
    end
    #2 reset = 1'b0;
    rd_mem = 1'b0;
    tick();
    run_access(1'b0, 8'h20, 16'h0000);
    tests_run++;
    if (data_bus_a !== 16'h5A5A) begin
      tests_failed++;
      $display("[TB] FAIL reset_keeps_mem got %h expected 5a5a", data_bus_a);
    end
  endtask

  task automatic test_reset_abort_write();
    do_load(8'h30, 16'h1111);
    adr_bus = 8'h30; data_in = 16'h2222; wr_mem = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    wr_mem = 1'b0;
    tick();
    run_access(1'b0, 8'h30, 16'h0000);
    tests_run++;
    if (data_bus_a !== 16'h1111) begin
      tests_failed++;
      $display("[TB] FAIL reset_abort_write got %h expected 1111", data_bus_a);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_ready;
    logic [15:0] exp_data;
    for (int i = 0; i < 4; i++) do_load(8'(i), 16'hA000 + 16'(i));
    adr_bus = 8'h00; rd_mem = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_ready = (k % 2 == 0);
      exp_data  = 16'hA000 + 16'(k / 2);
      tests_run++;
      if (mem_ready_c !== exp_ready || data_bus_c !== exp_data) begin
        tests_failed++;
        $display("[TB] FAIL b2b cycle %0d got ready=%b data=%h expected ready=%b data=%h",
                 k, mem_ready_c, data_bus_c, exp_ready, exp_data);
      end
      if (exp_ready) adr_bus = 8'(k / 2 + 1);
    end
    rd_mem = 1'b0;
  endtask

  initial begin
    adr_bus = '0; rd_mem = 1'b0; wr_mem = 1'b0; data_in = '0;
    ld_en = 1'b0; ld_adr = '0; ld_data = '0;
    test_reset();
    test_load_read();
    settle();
    test_write_read();
    settle();
    test_protocol_error();
    settle();
    test_range_error();
    settle();
    test_load_collision();
    settle();
    test_reset_midstream();
    settle();
    test_reset_abort_write();
    settle();
    test_back_to_back();
    settle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
